// File: rtl/timer_pkg.sv
// Shared defaults and helpers for the lap timer.
// Holds default parameter values and a constant-foldable clog2.
package timer_pkg;

    localparam int SEC_MOD_DEF  = 60;
    localparam int MIN_W_DEF    = 4;
    localparam int TICK_DIV_DEF = 1;

    // Number of bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: divides enabled clk cycles by TICK_DIV.
// Ports: clk, rst (async low), en, clr -> step (comb, one cycle).
module tick_gen
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int PW = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign step    = en & ~clr & at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/lap_timer.sv
// Minutes:seconds up/down timer with prescaler, preload and lap capture.
// Ports: clk, rst, en, clr, up, load, load_min, load_sec, lap ->
//        count, lap_count, tick, expired, ovf.
module lap_timer
    import timer_pkg::*;
#(
    parameter  int SEC_MOD  = SEC_MOD_DEF,
    parameter  int MIN_W    = MIN_W_DEF,
    parameter  int TICK_DIV = TICK_DIV_DEF,
    localparam int SEC_W    = clog2(SEC_MOD)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   up,
    input  logic                   load,
    input  logic [MIN_W-1:0]       load_min,
    input  logic [SEC_W-1:0]       load_sec,
    input  logic                   lap,
    output logic [MIN_W+SEC_W-1:0] count,
    output logic [MIN_W+SEC_W-1:0] lap_count,
    output logic                   tick,
    output logic                   expired,
    output logic                   ovf
);

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD - 1);
    localparam logic [SEC_W:0]   SEC_LIM = (SEC_W + 1)'(SEC_MOD);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    logic [MIN_W-1:0]       min_q, min_n;
    logic [SEC_W-1:0]       sec_q, sec_n;
    logic [MIN_W+SEC_W-1:0] lap_q;
    logic                   tick_q, tick_n;
    logic                   exp_q, exp_n;
    logic                   ovf_q, ovf_n;
    logic                   step;

    // Load also restarts the prescaler, so it shares the clear path.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .step (step)
    );

    always_comb begin
        min_n  = min_q;
        sec_n  = sec_q;
        tick_n = 1'b0;
        exp_n  = 1'b0;
        ovf_n  = ovf_q;
        if (clr) begin
            min_n = '0;
            sec_n = '0;
            ovf_n = 1'b0;
        end else if (load) begin
            min_n = load_min;
            sec_n = ({1'b0, load_sec} >= SEC_LIM) ? SEC_MAX : load_sec;
        end else if (step) begin
            if (up) begin
                tick_n = 1'b1;
                if (sec_q == SEC_MAX) begin
                    sec_n = '0;
                    if (min_q == MIN_MAX) begin
                        min_n = '0;
                        ovf_n = 1'b1;
                    end else begin
                        min_n = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_n = sec_q + SEC_W'(1);
                end
            end else if (sec_q != '0) begin
                tick_n = 1'b1;
                sec_n  = sec_q - SEC_W'(1);
                exp_n  = (min_q == '0) && (sec_q == SEC_W'(1));
            end else if (min_q != '0) begin
                tick_n = 1'b1;
                sec_n  = SEC_MAX;
                min_n  = min_q - MIN_W'(1);
            end
            // Down at 0:00 holds silently.
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q  <= '0;
            sec_q  <= '0;
            lap_q  <= '0;
            tick_q <= 1'b0;
            exp_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            min_q  <= min_n;
            sec_q  <= sec_n;
            tick_q <= tick_n;
            exp_q  <= exp_n;
            ovf_q  <= ovf_n;
            // Captures the value before this edge's update.
            if (lap) begin
                lap_q <= {min_q, sec_q};
            end
        end
    end

    assign count     = {min_q, sec_q};
    assign lap_count = lap_q;
    assign tick      = tick_q;
    assign expired   = exp_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: three instances (TICK_DIV 1, 4, 3) share stimulus
// and are compared each cycle to a seconds-total model.
module tb_lap_timer;

    localparam int MOD  = 60;
    localparam int MINS = 16;
    localparam int TOT  = MOD * MINS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, up = 1'b0, load = 1'b0, lap = 1'b0;
    logic [3:0] load_min = '0;
    logic [5:0] load_sec = '0;

    logic [9:0] cnt_o [3];
    logic [9:0] lap_o [3];
    logic       tick_o[3];
    logic       exp_o [3];
    logic       ovf_o [3];

    int DIV[3] = '{1, 4, 3};

    int m_t[3], m_pre[3], m_lap[3];
    bit m_tk[3], m_ex[3], m_ov[3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lap_timer u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up(up), .load(load),
        .load_min(load_min), .load_sec(load_sec), .lap(lap),
        .count(cnt_o[0]), .lap_count(lap_o[0]), .tick(tick_o[0]),
        .expired(exp_o[0]), .ovf(ovf_o[0])
    );
    lap_timer #(.TICK_DIV(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up(up), .load(load),
        .load_min(load_min), .load_sec(load_sec), .lap(lap),
        .count(cnt_o[1]), .lap_count(lap_o[1]), .tick(tick_o[1]),
        .expired(exp_o[1]), .ovf(ovf_o[1])
    );
    lap_timer #(.TICK_DIV(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .up(up), .load(load),
        .load_min(load_min), .load_sec(load_sec), .lap(lap),
        .count(cnt_o[2]), .lap_count(lap_o[2]), .tick(tick_o[2]),
        .expired(exp_o[2]), .ovf(ovf_o[2])
    );

    function automatic logic [9:0] pack(input int v);
        return {4'(v / MOD), 6'(v % MOD)};
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %0h want %0h",
                     nm, i, $time, act, exp);
        end
    endtask

    // Model: count held as a total number of seconds.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_t[i] = 0; m_pre[i] = 0; m_lap[i] = 0;
                m_tk[i] = 0; m_ex[i] = 0; m_ov[i] = 0;
            end else begin
                if (lap) m_lap[i] = m_t[i];
                m_tk[i] = 0;
                m_ex[i] = 0;
                if (clr) begin
                    m_t[i] = 0; m_pre[i] = 0; m_ov[i] = 0;
                end else if (load) begin
                    m_t[i] = int'(load_min) * MOD
                           + ((int'(load_sec) > MOD - 1) ? MOD - 1 : int'(load_sec));
                    m_pre[i] = 0;
                end else if (en) begin
                    if (m_pre[i] == DIV[i] - 1) begin
                        m_pre[i] = 0;
                        if (up) begin
                            m_tk[i] = 1;
                            if (m_t[i] == TOT - 1) begin
                                m_t[i] = 0;
                                m_ov[i] = 1;
                            end else begin
                                m_t[i]++;
                            end
                        end else if (m_t[i] > 0) begin
                            m_t[i]--;
                            m_tk[i] = 1;
                            if (m_t[i] == 0) m_ex[i] = 1;
                        end
                    end else begin
                        m_pre[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("count", i, 32'(cnt_o[i]), 32'(pack(m_t[i])));
            chk("lap_count", i, 32'(lap_o[i]), 32'(pack(m_lap[i])));
            chk("tick", i, 32'(tick_o[i]), 32'(m_tk[i]));
            chk("expired", i, 32'(exp_o[i]), 32'(m_ex[i]));
            chk("ovf", i, 32'(ovf_o[i]), 32'(m_ov[i]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int first;

        cyc(2);
        chk("rst_count", 0, 32'(cnt_o[0]), 32'd0);
        chk("rst_ovf", 1, 32'(ovf_o[1]), 32'd0);
        rst = 1'b1;

        // 60 steps at TICK_DIV=1
        up = 1'b1; en = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tick_o[0]) n++;
        end
        chk("up60_count", 0, 32'(cnt_o[0]), 32'({4'd1, 6'd0}));
        chk("up60_ticks", 0, 32'(n), 32'd60);
        chk("up60_div4", 1, 32'(cnt_o[1]), 32'({4'd0, 6'd15}));

        // down expiry at TICK_DIV=4
        load = 1'b1; load_min = 4'd0; load_sec = 6'd2; up = 1'b0;
        cyc(1);
        load = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (exp_o[1]) n++;
        end
        chk("dn_0_1", 1, 32'(cnt_o[1]), 32'({4'd0, 6'd1}));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (exp_o[1]) n++;
        end
        chk("dn_0_0", 1, 32'(cnt_o[1]), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (exp_o[1]) n++;
        end
        chk("dn_hold", 1, 32'(cnt_o[1]), 32'd0);
        chk("dn_exp_once", 1, 32'(n), 32'd1);

        // up wrap sets sticky ovf
        load = 1'b1; load_min = 4'd15; load_sec = 6'd59; up = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        chk("wrap_count", 0, 32'(cnt_o[0]), 32'd0);
        chk("wrap_ovf", 0, 32'(ovf_o[0]), 32'd1);
        en = 1'b0;
        cyc(5);
        chk("ovf_sticky", 0, 32'(ovf_o[0]), 32'd1);

        // gated enable with a mid-run direction change
        for (int k = 0; k < 24; k++) begin
            en = (k % 3 != 1);
            up = (k < 12);
            cyc(1);
        end
        chk("ovf_still", 0, 32'(ovf_o[0]), 32'd1);
        en = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        chk("clr_ovf", 0, 32'(ovf_o[0]), 32'd0);

        // clr + load + lap together
        load = 1'b1; load_min = 4'd3; load_sec = 6'd17;
        cyc(1);
        clr = 1'b1; load_min = 4'd7; load_sec = 6'd5; lap = 1'b1;
        cyc(1);
        clr = 1'b0; load = 1'b0; lap = 1'b0;
        chk("cll_count", 2, 32'(cnt_o[2]), 32'd0);
        chk("cll_lap", 2, 32'(lap_o[2]), 32'({4'd3, 6'd17}));

        // load_sec saturation
        load = 1'b1; load_min = 4'd2; load_sec = 6'd63;
        cyc(1);
        load = 1'b0;
        chk("sat", 0, 32'(cnt_o[0]), 32'({4'd2, 6'd59}));

        // async reset mid-count at TICK_DIV=3
        en = 1'b1; up = 1'b1; lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        cyc(4);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 2, 32'(cnt_o[2]), 32'd0);
        chk("arst_lap", 2, 32'(lap_o[2]), 32'd0);
        chk("arst_tick", 2, 32'(tick_o[2]), 32'd0);
        chk("arst_exp", 2, 32'(exp_o[2]), 32'd0);
        chk("arst_ovf", 2, 32'(ovf_o[2]), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (tick_o[2]) begin
                first = k;
                break;
            end
        end
        chk("arst_first", 2, 32'(first), 32'd3);
        en = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter SEC_MOD, default 60: modulus of the seconds field; legal range 2..256.
REQ-002 Parameter MIN_W, default 4: width of the minutes field.
REQ-003 Parameter TICK_DIV, default 1: number of enabled clk cycles per seconds step; legal range 1..65535.
REQ-004 Derived constant SEC_W = clog2(SEC_MOD) SHALL size the seconds field.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 en  in  1  count enable; the prescaler advances only while high.
REQ-008 clr  in  1  synchronous clear of count, prescaler and flags.
REQ-009 up  in  1  mode: 1 = count up, 0 = count down; sampled every cycle.
REQ-010 load  in  1  synchronous preload strobe.
REQ-011 load_min  in  MIN_W  preload value for minutes.
REQ-012 load_sec  in  SEC_W  preload value for seconds.
REQ-013 lap  in  1  capture strobe for lap_count.
REQ-014 count  out  MIN_W+SEC_W  current value {minutes, seconds}.
REQ-015 lap_count  out  MIN_W+SEC_W  last captured value.
REQ-016 tick  out  1  one-cycle pulse on each cycle where the seconds field steps.
REQ-017 expired  out  1  one-cycle pulse when a down count reaches 0:00.
REQ-018 ovf  out  1  sticky flag set when an up count wraps the minutes field.

Function
REQ-019 Prescaler: an internal counter 0..TICK_DIV-1 SHALL increment on each cycle with en=1; a step occurs when en=1 and prescaler=TICK_DIV-1, and the prescaler then returns to 0.
REQ-020 en=0 SHALL freeze the prescaler and count with no loss of partial progress.
REQ-021 Up step: sec<SEC_MOD-1 -> sec+1; sec=SEC_MOD-1 -> sec=0 and min+1.
REQ-022 Up wrap: at {2^MIN_W-1, SEC_MOD-1}, a step SHALL give {0,0} and set ovf.
REQ-023 Down step: sec>0 -> sec-1; sec=0 and min>0 -> sec=SEC_MOD-1 and min-1.
REQ-024 Down at {0,0}: count SHALL hold, tick SHALL stay 0, and expired SHALL stay 0 (no re-fire).
REQ-025 A down step from {0,1} to {0,0} SHALL assert expired in the same cycle that count becomes {0,0}, i.e. registered together with the count update.
REQ-026 tick SHALL be registered and asserted in the cycle the updated count is first visible.
REQ-027 Priority per cycle: clr > load > step; lap is independent of all three.
REQ-028 clr=1: count={0,0}, prescaler=0, ovf=0; tick=0 and expired=0 next cycle; lap_count is unaffected.
REQ-029 load=1: count={load_min, load_sec}, prescaler=0, no step that cycle, ovf unchanged.
REQ-030 load_sec >= SEC_MOD SHALL be saturated to SEC_MOD-1.
REQ-031 lap=1: lap_count SHALL capture the count value present before this edge's update (latency 1).
REQ-032 lap=1 together with clr or load SHALL still capture the pre-update value.
REQ-033 A change of up between steps SHALL take effect at the next step; the prescaler is not reset.
REQ-034 With TICK_DIV=1, a step SHALL occur on every cycle with en=1.

Reset
REQ-035 rst low SHALL immediately force count=0, lap_count=0, prescaler=0, tick=0, expired=0 and ovf=0, regardless of clk.
REQ-036 rst asserted mid-count SHALL discard all partial prescaler progress.
REQ-037 After rst deasserts, the first step SHALL require TICK_DIV enabled cycles.

Structure
REQ-038 Package timer_pkg SHALL hold the default parameter values and a clog2 helper function.
REQ-039 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; ports clk, rst, en, clr; output step).
REQ-040 All minute/second arithmetic SHALL be performed at field width, with no implicit truncation warnings.

Verification
REQ-041 Defaults, up=1, en=1 held for 60 cycles from reset -> count={1,0}, 60 tick pulses observed.
REQ-042 TICK_DIV=4, load {0,2}, up=0, en=1 -> count {0,1} after 4 cycles, {0,0} after 8, expired pulsed once, count held for 20 more cycles.
REQ-043 Up count at {15,59} plus one step -> count {0,0}, ovf=1; ovf stays 1 until clr.
REQ-044 clr, load and lap asserted together at {3,17} -> count {0,0}, lap_count {3,17}.
REQ-045 load_sec=63 with SEC_MOD=60 -> seconds field reads 59.
REQ-046 rst pulsed low between clk edges mid-count with TICK_DIV=3 -> all outputs 0 immediately, first tick 3 enabled cycles after release.
